bus_rr_arbiter: RTL and testbench

Parametrised shared-bus interconnect: NUM_M masters contend for one bus, NUM_S slaves are selected by address decode. It generalises the fixed two-master/three-slave bus with a round-robin arbiter, an optional grant-hold limit, a registered read-data return path and an unmapped-access error flag. It sits between the DMA/CPU masters and the memory-mapped peripheral slaves.

---
 rtl/bus_rr_arbiter.sv | 113 +++++++++++
 tb/tb_bus_rr_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/bus_rr_arbiter.sv
// Shared-bus interconnect: NUM_M masters arbitrated round-robin onto one bus,
// NUM_S slaves selected by top-3-bit address decode, registered read return.
module bus_rr_arbiter #(
  parameter int NUM_M    = 2,
  parameter int NUM_S    = 3,
  parameter int AW       = 8,
  parameter int DW       = 32,
  parameter int MAX_HOLD = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_M-1:0]    M_req,
  input  logic [NUM_M-1:0]    M_wr,
  input  logic [NUM_M*AW-1:0] M_address,
  input  logic [NUM_M*DW-1:0] M_dout,
  output logic [NUM_M-1:0]    M_grant,
  output logic [DW-1:0]       M_din,
  output logic                bus_err,
  input  logic [NUM_S*DW-1:0] S_dout,
  output logic [NUM_S-1:0]    S_sel,
  output logic [AW-1:0]       S_address,
  output logic                S_wr,
  output logic [DW-1:0]       S_din
);
  localparam int MW   = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int HW   = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int HLIM = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
  localparam logic [HW-1:0] HOLD_LIM = HW'(HLIM);

  logic [NUM_M-1:0] grant_q, grant_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [DW-1:0]    din_q, din_d;
  logic             err_q, err_d;

  logic [MW-1:0] owner, nxt;
  logic          owner_req, others_req, at_limit, found;
  logic [2:0]    idx;
  logic          active, mapped;

  always_comb begin
    owner = '0;
    for (int i = 0; i < NUM_M; i++)
      if (grant_q[i]) owner = MW'(i);
  end

  assign owner_req  = M_req[owner];
  assign others_req = |(M_req & ~grant_q);
  assign at_limit   = (MAX_HOLD != 0) && (hold_q == HOLD_LIM);

  assign S_address = M_address[int'(owner)*AW +: AW];
  assign S_din     = M_dout[int'(owner)*DW +: DW];
  assign S_wr      = M_wr[owner] & owner_req;

  assign idx    = S_address[AW-1:AW-3];
  assign active = owner_req;
  assign mapped = int'(idx) < NUM_S;

  always_comb begin
    S_sel = '0;
    for (int j = 0; j < NUM_S; j++)
      S_sel[j] = active && (idx == 3'(j));
  end

  // Read data from the slave selected this cycle, presented next cycle.
  always_comb begin
    din_d = '0;
    for (int j = 0; j < NUM_S; j++)
      if (S_sel[j]) din_d = S_dout[j*DW +: DW];
    err_d = active & ~mapped;
  end

  // First requester after the owner, wrapping; owner itself is never a candidate.
  always_comb begin
    found = 1'b0;
    nxt   = owner;
    for (int k = 1; k < NUM_M; k++) begin
      if (!found && M_req[(int'(owner) + k) % NUM_M]) begin
        found = 1'b1;
        nxt   = MW'((int'(owner) + k) % NUM_M);
      end
    end
  end

  always_comb begin
    grant_d = grant_q;
    hold_d  = '0;
    if (owner_req && !(at_limit && others_req)) begin
      // Keep the bus; the counter parks at the limit when nobody else waits.
      hold_d = (MAX_HOLD == 0 || at_limit) ? hold_q : hold_q + 1'b1;
    end else if (others_req) begin
      grant_d      = '0;
      grant_d[nxt] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q <= NUM_M'(1);
      hold_q  <= '0;
      din_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      grant_q <= grant_d;
      hold_q  <= hold_d;
      din_q   <= din_d;
      err_q   <= err_d;
    end
  end

  assign M_grant = grant_q;
  assign M_din   = din_q;
  assign bus_err = err_q;
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench for bus_rr_arbiter: directed test-plan steps followed by
// random traffic, all checked against an owner/hold-count reference model.
module tb_bus_rr_arbiter;
  localparam int NM = 3, NS = 3, AW = 8, DW = 32, MH = 2;

  logic clk = 1'b0, rst;
  logic [NM-1:0]    M_req, M_wr, M_grant;
  logic [NM*AW-1:0] M_address;
  logic [NM*DW-1:0] M_dout;
  logic [DW-1:0]    M_din, S_din;
  logic             bus_err, S_wr;
  logic [NS*DW-1:0] S_dout;
  logic [NS-1:0]    S_sel;
  logic [AW-1:0]    S_address;

  bus_rr_arbiter #(.NUM_M(NM), .NUM_S(NS), .AW(AW), .DW(DW), .MAX_HOLD(MH)) dut (
    .clk(clk), .reset(rst), .M_req(M_req), .M_wr(M_wr), .M_address(M_address),
    .M_dout(M_dout), .M_grant(M_grant), .M_din(M_din), .bus_err(bus_err),
    .S_dout(S_dout), .S_sel(S_sel), .S_address(S_address), .S_wr(S_wr), .S_din(S_din)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int own, hold;
  logic [DW-1:0] e_din;
  logic          e_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Mid-cycle check of the combinational bus mux/decode against the model owner.
  task automatic mid();
    logic [AW-1:0] a;
    logic [NS-1:0] esel;
    int ix;
    #2;
    a  = M_address[own*AW +: AW];
    ix = int'(a) >> (AW - 3);
    esel = '0;
    if (M_req[own] && ix < NS) esel[ix] = 1'b1;
    chk("grant_mid", 64'(M_grant), 64'(1) << own);
    chk("s_sel", 64'(S_sel), 64'(esel));
    chk("s_addr", 64'(S_address), 64'(a));
    chk("s_wr", 64'(S_wr), 64'(M_req[own] & M_wr[own]));
    chk("s_din", 64'(S_din), 64'(M_dout[own*DW +: DW]));
  endtask

  // Advance the model from the rules (sampled inputs), clock, then check registers.
  task automatic tick();
    logic [AW-1:0] a;
    int ix, nown, nhold;
    bit oth, act, lim;
    a   = M_address[own*AW +: AW];
    ix  = int'(a) >> (AW - 3);
    act = M_req[own];
    oth = 0;
    for (int i = 0; i < NM; i++) if (i != own && M_req[i]) oth = 1;
    lim = (hold == MH - 1);
    nown = own; nhold = 0;
    if (rst) begin
      nown = 0; e_din = '0; e_err = 1'b0;
    end else begin
      e_din = (act && ix < NS) ? S_dout[ix*DW +: DW] : '0;
      e_err = act && ix >= NS;
      if (act && !(lim && oth)) nhold = lim ? hold : hold + 1;
      else if (oth) begin
        for (int k = NM - 1; k >= 1; k--)
          if (M_req[(own + k) % NM]) nown = (own + k) % NM;
      end
    end
    @(posedge clk); #1;
    own = nown; hold = nhold;
    chk("grant_q", 64'(M_grant), 64'(1) << own);
    chk("m_din", 64'(M_din), 64'(e_din));
    chk("bus_err", 64'(bus_err), 64'(e_err));
  endtask

  task automatic cyc();
    mid();
    tick();
  endtask

  initial begin
    logic [NM-1:0] rr_exp [7];
    logic [AW-1:0] dec_a [4];
    logic [DW-1:0] dec_d [4];
    logic [NS-1:0] dec_s [4];
    rr_exp = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001};
    dec_a  = '{8'h01, 8'h21, 8'h41, 8'hA0};
    dec_d  = '{32'd1, 32'd2, 32'd3, 32'd0};
    dec_s  = '{3'b001, 3'b010, 3'b100, 3'b000};

    rst = 1'b1; M_req = '0; M_wr = '0; M_address = '0; M_dout = '0; S_dout = '0;
    @(posedge clk); @(posedge clk); #1;
    own = 0; hold = 0; e_din = '0; e_err = 1'b0;

    // Reset with everyone requesting, then round-robin with hold limit 2.
    M_req = 3'b111;
    repeat (2) cyc();
    chk("rst_grant", 64'(M_grant), 64'(3'b001));
    chk("rst_din", 64'(M_din), 64'd0);
    chk("rst_err", 64'(bus_err), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      mid();
      chk("rr_seq", 64'(M_grant), 64'(rr_exp[i]));
      tick();
    end

    // Decode with M0 owning the bus.
    rst = 1'b1; M_req = 3'b001; cyc(); rst = 1'b0;
    S_dout = {32'd3, 32'd2, 32'd1};
    for (int i = 0; i < 4; i++) begin
      M_address[7:0] = dec_a[i];
      mid();
      chk("dec_sel", 64'(S_sel), 64'(dec_s[i]));
      tick();
      chk("dec_din", 64'(M_din), 64'(dec_d[i]));
      chk("dec_err", 64'(bus_err), 64'(i == 3));
    end

    // Hand-off M0 -> M1, then M1 parks idle with its write strobe high.
    M_req = 3'b001; cyc();
    M_req = 3'b010; cyc();
    chk("handoff", 64'(M_grant), 64'(3'b010));
    M_req = 3'b000; M_wr = 3'b010;
    repeat (3) begin
      mid();
      chk("park_wr", 64'(S_wr), 64'd0);
      tick();
      chk("park_grant", 64'(M_grant), 64'(3'b010));
    end

    // Hold saturation: only M1 requests.
    M_req = 3'b010; M_wr = '0;
    repeat (6) begin
      tick();
      chk("hold_sat", 64'(M_grant), 64'(3'b010));
    end

    // Write path through M1.
    M_wr = 3'b010; M_address[15:8] = 8'h22; M_dout[63:32] = 32'h0024;
    mid();
    chk("wr_s_wr", 64'(S_wr), 64'd1);
    chk("wr_sel", 64'(S_sel), 64'(3'b010));
    chk("wr_din", 64'(S_din), 64'h24);
    chk("wr_addr", 64'(S_address), 64'h22);
    tick();

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(39) == 0);
      M_req     = NM'($urandom);
      M_wr      = NM'($urandom);
      M_address = (NM*AW)'($urandom);
      M_dout    = {$urandom, $urandom, $urandom};
      S_dout    = {$urandom, $urandom, $urandom};
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
